// File: rtl/uart_cmd_ctrl_if.sv
// Byte-wide write port from the command sequencer into the GPU register/VRAM space.
// A write transfers on a cycle where wr_valid && wr_ready; the master holds
// wr_addr/wr_data stable while wr_valid is high.
interface uart_cmd_ctrl_if;
    logic        wr_valid;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_ready;

    modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/uart_cmd_ctrl.sv
// Host-command sequencer behind the UART receiver.
// Parses A5 | CMD | ADDR_HI | ADDR_LO | LEN | DATA[LEN] | CHK frames, buffers and
// XOR-verifies the payload, then issues auto-incrementing byte writes on the write port.
module uart_cmd_ctrl #(
    parameter int unsigned MAX_LEN       = 16,
    parameter int unsigned TIMEOUT_TICKS = 2048
) (
    input  logic                   CLK,
    input  logic                   rst_n,
    input  logic                   os_tick,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    input  logic                   rx_ferr,
    uart_cmd_ctrl_if.master        wr,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   err_valid,
    output logic [2:0]             err_code
);

    localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned TW    = $clog2(TIMEOUT_TICKS + 1);

    typedef enum logic [2:0] {
        S_SYNC, S_CMD, S_AH, S_AL, S_LEN, S_DATA, S_CHK, S_ISSUE
    } state_t;

    typedef enum logic [2:0] {
        E_NONE     = 3'd0,
        E_BAD_CMD  = 3'd1,
        E_BAD_LEN  = 3'd2,
        E_CHK_FAIL = 3'd3,
        E_TIMEOUT  = 3'd4,
        E_FRAMING  = 3'd5,
        E_OVERRUN  = 3'd6
    } err_t;

    state_t           state;
    logic [15:0]      base_addr;
    logic [IDX_W-1:0] last_idx;
    logic [IDX_W-1:0] idx;
    logic [7:0]       xor_acc;
    logic [TW-1:0]    tcnt;
    logic [7:0]       pbuf [MAX_LEN];
    logic             buf_we;

    // A byte arriving together with a framing error is dropped, so it never lands in the buffer.
    assign buf_we = (state == S_DATA) && rx_valid && !rx_ferr;
    assign busy   = (state != S_SYNC);

    // Payload storage; no reset needed, every entry is written before it is read.
    always_ff @(posedge CLK) begin
        if (buf_we) begin
            pbuf[idx] <= rx_data;
        end
    end

    // Frame parser, timeout supervisor and write issuer.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_SYNC;
            base_addr   <= '0;
            last_idx    <= '0;
            idx         <= '0;
            xor_acc     <= '0;
            tcnt        <= '0;
            wr.wr_valid <= 1'b0;
            wr.wr_addr  <= '0;
            wr.wr_data  <= '0;
            frame_done  <= 1'b0;
            err_valid   <= 1'b0;
            err_code    <= '0;
        end else begin
            frame_done <= 1'b0;
            err_valid  <= 1'b0;
            case (state)
                S_SYNC: begin
                    xor_acc <= '0;
                    tcnt    <= '0;
                    if (rx_ferr) begin
                        err_valid <= 1'b1;
                        err_code  <= E_FRAMING;
                    end else if (rx_valid && rx_data == 8'hA5) begin
                        state <= S_CMD;
                    end
                end
                S_ISSUE: begin
                    // Receiver activity here cannot be parsed; flag it but keep issuing.
                    if (rx_valid || rx_ferr) begin
                        err_valid <= 1'b1;
                        err_code  <= E_OVERRUN;
                    end
                    if (wr.wr_valid && wr.wr_ready) begin
                        if (idx == last_idx) begin
                            wr.wr_valid <= 1'b0;
                            frame_done  <= 1'b1;
                            state       <= S_SYNC;
                        end else begin
                            idx        <= idx + 1'b1;
                            wr.wr_addr <= wr.wr_addr + 16'd1;
                            wr.wr_data <= pbuf[idx + 1'b1];
                        end
                    end
                end
                default: begin
                    // In-frame states: framing error beats a byte, a byte beats the timeout tick.
                    if (rx_ferr) begin
                        err_valid <= 1'b1;
                        err_code  <= E_FRAMING;
                        state     <= S_SYNC;
                    end else if (rx_valid) begin
                        tcnt <= '0;
                        case (state)
                            S_CMD: begin
                                if (rx_data == 8'h01) begin
                                    xor_acc <= xor_acc ^ rx_data;
                                    state   <= S_AH;
                                end else begin
                                    err_valid <= 1'b1;
                                    err_code  <= E_BAD_CMD;
                                    state     <= S_SYNC;
                                end
                            end
                            S_AH: begin
                                base_addr[15:8] <= rx_data;
                                xor_acc         <= xor_acc ^ rx_data;
                                state           <= S_AL;
                            end
                            S_AL: begin
                                base_addr[7:0] <= rx_data;
                                xor_acc        <= xor_acc ^ rx_data;
                                state          <= S_LEN;
                            end
                            S_LEN: begin
                                if (rx_data == 8'd0 || 32'(rx_data) > MAX_LEN) begin
                                    err_valid <= 1'b1;
                                    err_code  <= E_BAD_LEN;
                                    state     <= S_SYNC;
                                end else begin
                                    last_idx <= IDX_W'(rx_data - 8'd1);
                                    idx      <= '0;
                                    xor_acc  <= xor_acc ^ rx_data;
                                    state    <= S_DATA;
                                end
                            end
                            S_DATA: begin
                                xor_acc <= xor_acc ^ rx_data;
                                if (idx == last_idx) begin
                                    idx   <= '0;
                                    state <= S_CHK;
                                end else begin
                                    idx <= idx + 1'b1;
                                end
                            end
                            S_CHK: begin
                                if (rx_data == xor_acc) begin
                                    wr.wr_valid <= 1'b1;
                                    wr.wr_addr  <= base_addr;
                                    wr.wr_data  <= pbuf[0];
                                    idx         <= '0;
                                    state       <= S_ISSUE;
                                end else begin
                                    err_valid <= 1'b1;
                                    err_code  <= E_CHK_FAIL;
                                    state     <= S_SYNC;
                                end
                            end
                            default: state <= S_SYNC;
                        endcase
                    end else if (os_tick) begin
                        if (tcnt == TW'(TIMEOUT_TICKS - 1)) begin
                            err_valid <= 1'b1;
                            err_code  <= E_TIMEOUT;
                            state     <= S_SYNC;
                        end else begin
                            tcnt <= tcnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule
